// File: rtl/idex_pkg.sv
// idex_pkg: ID/EX control field layout, entry type and skid-buffer state encodings
package idex_pkg;
    localparam int WB_W    = 2;
    localparam int MEM_W   = 3;
    localparam int EX_W    = 4;
    localparam int EX_OFF  = 0;
    localparam int MEM_OFF = EX_OFF + EX_W;
    localparam int WB_OFF  = MEM_OFF + MEM_W;
    localparam int CTL_TOT = WB_W + MEM_W + EX_W;
    typedef struct packed {
        logic [CTL_TOT-1:0] ctl;
        logic [31:0]        npc;
        logic [31:0]        rd1;
        logic [31:0]        rd2;
        logic [31:0]        imm;
        logic [4:0]         rt;
        logic [4:0]         rd;
    } entry_t;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/idex_skid_buf.sv
// idex_skid_buf: two-entry skid buffer with registered in_ready and out_valid
module idex_skid_buf
    import idex_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    state_t state;
    logic [W-1:0] skid;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_data  <= '0;
            skid      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (clr) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (in_valid) begin
                    out_data  <= in_data;
                    state     <= ONE;
                    out_valid <= 1'b1;
                end
                ONE: if (in_valid && out_ready) begin
                    out_data <= in_data;
                end else if (in_valid) begin
                    skid     <= in_data;
                    state    <= FULL;
                    in_ready <= 1'b0;
                end else if (out_ready) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
                FULL: if (out_ready) begin
                    out_data <= skid;
                    state    <= ONE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with skid buffer, flush and ctl masking;
// IDEX_PERF_CNT_EN adds saturating stall_cnt/bubble_cnt outputs
module idex_pipe_reg
    import idex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTL_W  = CTL_TOT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CTL_W-1:0]    in_ctl,
    input  logic [4*DATA_W-1:0] in_data,
    input  logic [2*REG_W-1:0]  in_regs,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTL_W-1:0]    out_ctl,
    output logic [4*DATA_W-1:0] out_data,
    output logic [2*REG_W-1:0]  out_regs
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         bubble_cnt
`endif
);
    localparam int W = CTL_W + 4*DATA_W + 2*REG_W;
    logic [W-1:0] q;
    idex_skid_buf #(.W(W)) u_buf (
        .clk(clk),
        .rst(rst),
        .clr(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data({in_ctl, in_data, in_regs}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(q)
    );
    // a bubble must never write back or touch memory
    assign out_ctl  = out_valid ? q[W-1 -: CTL_W] : '0;
    assign out_data = q[2*REG_W +: 4*DATA_W];
    assign out_regs = q[2*REG_W-1:0];
`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed self-checking bench for idex_pipe_reg
module tb_idex_pipe_reg;
    logic         clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic         in_ready, out_valid;
    logic [8:0]   in_ctl = '0, out_ctl;
    logic [127:0] in_data = '0, out_data;
    logic [9:0]   in_regs = '0, out_regs;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0]  stall_cnt, bubble_cnt;
`endif
    int n_cmp = 0, n_bad = 0;

    idex_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctl(in_ctl), .in_data(in_data), .in_regs(in_regs),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctl(out_ctl), .out_data(out_data), .out_regs(out_regs)
`ifdef IDEX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] npc, input logic [8:0] ctl);
        in_valid = v;
        in_ctl   = ctl;
        in_data  = {npc, npc + 32'd1, npc + 32'd2, npc + 32'd3};
        in_regs  = npc[9:0];
    endtask

    initial begin
        repeat (2) tick();
        rst = 0;
        check("rst_ovalid", out_valid, 0);
        check("rst_iready", in_ready, 1);
        check("rst_ctl", out_ctl, 0);
        check("rst_data", out_data, 0);
        check("rst_regs", out_regs, 0);

        out_ready = 1;
        drive(1, 32'h4, 9'h1AB);
        tick();
        check("lat_ovalid", out_valid, 1);
        check("lat_npc", out_data[127:96], 32'h4);
        check("lat_ctl", out_ctl, 9'h1AB);
        check("lat_imm", out_data[31:0], 32'h7);
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h100 + i*4, 9'h0F0);
            tick();
            check("strm_ovalid", out_valid, 1);
            check("strm_npc", out_data[127:96], 32'h100 + i*4);
            check("strm_iready", in_ready, 1);
        end
        drive(0, 0, 0);
        tick();
        check("drain_ovalid", out_valid, 0);
        check("drain_ctl", out_ctl, 0);

        out_ready = 0;
        drive(1, 32'hA0, 9'h001);
        tick();
        check("a_npc", out_data[127:96], 32'hA0);
        check("a_iready", in_ready, 1);
        drive(1, 32'hB0, 9'h002);
        tick();
        check("b_iready", in_ready, 0);
        check("b_hold_npc", out_data[127:96], 32'hA0);
        drive(1, 32'hC0, 9'h003);
        tick();
        check("full_hold_npc", out_data[127:96], 32'hA0);
        check("full_hold_ctl", out_ctl, 9'h001);
        drive(0, 0, 0);
        out_ready = 1;
        tick();
        check("pop_a_npc", out_data[127:96], 32'hB0);
        check("pop_a_ctl", out_ctl, 9'h002);
        check("pop_a_iready", in_ready, 1);
        tick();
        check("pop_b_ovalid", out_valid, 0);

        out_ready = 0;
        drive(1, 32'hA4, 9'h011);
        tick();
        drive(1, 32'hB4, 9'h012);
        tick();
        check("fl_full", in_ready, 0);
        flush = 1;
        drive(1, 32'hDD, 9'h1FF);
        tick();
        flush = 0;
        drive(0, 0, 0);
        check("fl_ovalid", out_valid, 0);
        check("fl_ctl", out_ctl, 0);
        check("fl_iready", in_ready, 1);
        out_ready = 1;
        tick();
        check("fl_gone", out_valid, 0);

        out_ready = 0;
        drive(1, 32'hE0, 9'h0AA);
        tick();
        drive(1, 32'hE4, 9'h0BB);
        tick();
        check("rs_full", in_ready, 0);
        rst = 1;
        drive(0, 0, 0);
        tick();
        rst = 0;
        check("rs_ovalid", out_valid, 0);
        check("rs_ctl", out_ctl, 0);
        check("rs_data", out_data, 0);
        check("rs_regs", out_regs, 0);
        check("rs_iready", in_ready, 1);
        tick();
        check("rs_idle", out_valid, 0);

`ifdef IDEX_PERF_CNT_EN
        rst = 1;
        tick();
        rst = 0;
        check("pc_rst", stall_cnt, 0);
        drive(1, 32'hF0, 9'h001);
        tick();
        drive(0, 0, 0);
        check("pc_nostall", stall_cnt, 0);
        repeat (5) tick();
        check("pc_stall5", stall_cnt, 5);
        check("pc_bubble", bubble_cnt, 1);
        force dut.stall_cnt = 32'hFFFFFFFF;
        #1;
        release dut.stall_cnt;
        tick();
        check("pc_sat", stall_cnt, 32'hFFFFFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/idex_pipe_reg.md
IDEX_PIPE_REG -- requirements
Module: idex_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, datapath word width.
REQ-002 Parameter REG_W, default 5, register-specifier width.
REQ-003 Parameter CTL_W, default 9, packed control width (WB 2 + MEM 3 + EX 4).
REQ-004 Port clk  in  1  clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port flush  in  1  discard all held and incoming entries.
REQ-007 Port in_valid  in  1  upstream (ID) entry present.
REQ-008 Port in_ready  out  1  stage can accept an entry this cycle.
REQ-009 Port in_ctl  in  CTL_W  packed control {wb,mem,ex}.
REQ-010 Port in_data  in  4*DATA_W  packed {npc,rd1,rd2,imm}.
REQ-011 Port in_regs  in  2*REG_W  packed {rt,rd}.
REQ-012 Port out_valid  out  1  entry presented to EX.
REQ-013 Port out_ready  in  1  EX accepts the presented entry.
REQ-014 Ports out_ctl/out_data/out_regs  out  CTL_W/4*DATA_W/2*REG_W  presented entry.

Function
REQ-015 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-016 Two-entry storage: main register (drives outputs) plus skid register.
REQ-017 States EMPTY (none held), ONE (main valid), FULL (main and skid valid).
REQ-018 EMPTY: in transfer -> ONE; main loaded; latency in->out exactly 1 cycle.
REQ-019 ONE: in and out transfer together -> ONE, main reloaded; in only -> FULL, entry into skid; out only -> EMPTY.
REQ-020 FULL: out transfer -> ONE, skid moves to main; in_valid ignored since in_ready=0.
REQ-021 in_ready is a register output, 1 in EMPTY/ONE, 0 in FULL; it has no combinational path from out_ready.
REQ-022 Sustained in_valid=out_ready=1 yields one transfer per cycle with no bubbles.
REQ-023 out_valid=1 exactly in ONE/FULL; out_* stable while out_valid && !out_ready.
REQ-024 out_ctl is forced to all-zero whenever out_valid=0 (bubble never writes back or accesses memory).
REQ-025 flush=1: next state EMPTY; a coincident in transfer is discarded; a coincident out transfer still counts as consumed.
REQ-026 Entries are never reordered, duplicated or lost except by flush/rst.

Reset
REQ-027 rst has priority over flush and all transfers.
REQ-028 On reset: state EMPTY, out_valid=0, in_ready=1 on the first cycle after reset, out_ctl/out_data/out_regs all zero, skid zero.
REQ-029 Reset in FULL or ONE drops all entries with no partial output.

Configuration
REQ-030 Macro IDEX_PERF_CNT_EN defined: add outputs stall_cnt[31:0] (cycles with out_valid && !out_ready) and bubble_cnt[31:0] (cycles with out_valid=0).
REQ-031 Both counters saturate at 32'hFFFFFFFF, clear on rst, and are not affected by flush.
REQ-032 Macro undefined: counter ports and logic are absent; all other behaviour is identical.

Structure
REQ-033 Package idex_pkg holds CTL field widths and offsets (WB_W=2, MEM_W=3, EX_W=4), a packed entry typedef, and state encodings.
REQ-034 The two-entry storage is sub-module idex_skid_buf, parametrised on total entry width; the top level handles packing, flush and ctl masking.

Verification
REQ-035 Reset, then in_valid=1, in_data npc=0x4, out_ready=1 -> out_valid=1 next cycle, npc=0x4; steady stream of 8 entries drains in 8 consecutive cycles.
REQ-036 out_ready=0, push A, B -> in_ready=0 after B; out holds A; out_ready=1 -> A then B in order, in_ready=1 after A leaves.
REQ-037 FULL, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctl=0, in_ready=1; the flushed input never appears.
REQ-038 rst mid-stream in FULL -> all outputs zero, in_ready=1 the cycle after rst deasserts.
REQ-039 IDEX_PERF_CNT_EN defined, out_ready=0 for 5 cycles with a held entry -> stall_cnt=5; forced counter 32'hFFFFFFFF stays saturated.
